compare_debounce: RTL

- Sits directly downstream of the 8-bit magnitude comparator and consumes its one-hot AltB/AeqB/AgtB flags, one sample per valid cycle.
- Publishes a filtered relation that only changes after DEPTH consecutive identical valid samples.
- Emits a one-cycle change pulse and counts accepted relation changes.
- Flags malformed flag combinations from the comparator.

---
 rtl/compare_debounce_if.sv | 31 +++
 rtl/compare_debounce.sv | 106 ++++++++++
 2 files changed

// File: rtl/compare_debounce_if.sv
// compare_debounce_if: groups the comparator flag inputs and the filtered-relation outputs of compare_debounce.
`default_nettype none

interface compare_debounce_if #(
  parameter int CNT_W = 8
);
  logic             clear;
  logic             in_valid;
  logic             AltB;
  logic             AeqB;
  logic             AgtB;
  logic             stable_valid;
  logic             stable_lt;
  logic             stable_eq;
  logic             stable_gt;
  logic             change;
  logic             err;
  logic [CNT_W-1:0] change_cnt;

  modport master (
    output clear, in_valid, AltB, AeqB, AgtB,
    input  stable_valid, stable_lt, stable_eq, stable_gt, change, err, change_cnt
  );

  modport slave (
    input  clear, in_valid, AltB, AeqB, AgtB,
    output stable_valid, stable_lt, stable_eq, stable_gt, change, err, change_cnt
  );
endinterface

`default_nettype wire

// File: rtl/compare_debounce.sv
// ----------------------------------------------------------------------------
// compare_debounce: filters one-hot comparator flags; a relation is accepted after DEPTH identical samples.
// Option COMPARE_DEBOUNCE_STICKY_ERR_EN makes err sticky until rst/clear. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module compare_debounce #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  compare_debounce_if.slave   bus
);

  localparam logic [0:0] c_EMPTY  = 1'b0;
  localparam logic [0:0] c_STABLE = 1'b1;
  localparam logic [7:0] c_DEPTH  = 8'(DEPTH);

  logic [0:0]       r_state;
  logic [2:0]       r_cand;
  logic             r_cand_vld;
  logic [7:0]       r_run;
  logic [2:0]       r_stable;
  logic             r_stable_vld;
  logic             r_change;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic [2:0] w_flags;
  logic       w_onehot;
  logic       w_good;
  logic       w_bad;
  logic       w_match;
  logic [7:0] w_run_nxt;
  logic       w_accept;

  // Flags packed as {gt, eq, lt}; the candidate and stable relation use the same one-hot form.
  assign w_flags   = {bus.AgtB, bus.AeqB, bus.AltB};
  assign w_onehot  = (w_flags == 3'b001) || (w_flags == 3'b010) || (w_flags == 3'b100);
  assign w_good    = bus.in_valid && w_onehot;
  assign w_bad     = bus.in_valid && !w_onehot;
  assign w_match   = r_cand_vld && (w_flags == r_cand);
  assign w_run_nxt = !w_match ? 8'd1 : ((r_run == c_DEPTH) ? r_run : r_run + 8'd1);
  assign w_accept  = w_good && (w_run_nxt == c_DEPTH) &&
                     ((r_state == c_EMPTY) || (w_flags != r_stable));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= c_EMPTY;
      r_cand       <= 3'b000;
      r_cand_vld   <= 1'b0;
      r_run        <= 8'd0;
      r_stable     <= 3'b000;
      r_stable_vld <= 1'b0;
      r_change     <= 1'b0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
    end else if (bus.clear) begin
      r_state      <= c_EMPTY;
      r_cand       <= 3'b000;
      r_cand_vld   <= 1'b0;
      r_run        <= 8'd0;
      r_stable     <= 3'b000;
      r_stable_vld <= 1'b0;
      r_change     <= 1'b0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_change <= 1'b0;
`ifdef COMPARE_DEBOUNCE_STICKY_ERR_EN
      r_err    <= r_err | w_bad;
`else
      r_err    <= w_bad;
`endif
      if (w_bad) begin
        r_run      <= 8'd0;
        r_cand_vld <= 1'b0;
      end else if (w_good) begin
        r_cand     <= w_flags;
        r_cand_vld <= 1'b1;
        r_run      <= w_run_nxt;
        if (w_accept) begin
          r_state      <= c_STABLE;
          r_stable     <= w_flags;
          r_stable_vld <= 1'b1;
          r_change     <= 1'b1;
          if (r_cnt != '1) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end
    end
  end

  assign bus.stable_valid = r_stable_vld;
  assign bus.stable_lt    = r_stable[0];
  assign bus.stable_eq    = r_stable[1];
  assign bus.stable_gt    = r_stable[2];
  assign bus.change       = r_change;
  assign bus.err          = r_err;
  assign bus.change_cnt   = r_cnt;

endmodule

`default_nettype wire
